// File: rtl/subterranean_din_packer.sv
// Frames a byte-length message of 32-bit LE words into Subterranean duplex
// (din, din_size) calls, adding the trailing empty block plus blank_rounds.
// Ports: clk, arstn (sync active-high reset), start/msg_len/blank_rounds,
//   s_data/s_valid/s_ready (word input), m_din/m_din_size/m_din_valid/
//   m_din_ready (core side), busy, done.
// Option: define SUBTERRANEAN_PACKER_SKID_EN for a registered output stage.
module subterranean_din_packer #(
  parameter int LEN_WIDTH   = 16,
  parameter int BLANK_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   msg_len,
  input  logic [BLANK_WIDTH-1:0] blank_rounds,
  input  logic [31:0]            s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [31:0]            m_din,
  output logic [2:0]             m_din_size,
  output logic                   m_din_valid,
  input  logic                   m_din_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PAD,
    S_BLANK,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   rem_bytes_q, rem_bytes_d;
  logic [BLANK_WIDTH-1:0] rem_blank_q, rem_blank_d;

  logic [31:0] f_din;
  logic [2:0]  f_size;
  logic        f_valid;
  logic        f_ready;
  logic        full_w;
  logic [31:0] part_w;

`ifdef SUBTERRANEAN_PACKER_SKID_EN
  // Last block sits in the output register; wait for it before done.
  localparam state_e FIN = S_FLUSH;

  logic        ov_q;
  logic [31:0] od_q;
  logic [2:0]  os_q;

  assign f_ready = !ov_q || m_din_ready;

  always_ff @(posedge clk) begin
    if (arstn) begin
      ov_q <= 1'b0;
      od_q <= '0;
      os_q <= '0;
    end else if (f_ready) begin
      ov_q <= f_valid;
      od_q <= f_din;
      os_q <= f_size;
    end
  end

  assign m_din       = od_q;
  assign m_din_size  = os_q;
  assign m_din_valid = ov_q;
`else
  localparam state_e FIN = S_DONE;

  assign f_ready     = m_din_ready;
  assign m_din       = f_din;
  assign m_din_size  = f_size;
  assign m_din_valid = f_valid;
`endif

  assign full_w = rem_bytes_q >= LEN_WIDTH'(4);

  // Bytes at or above the remaining count are zeroed.
  always_comb begin
    part_w = '0;
    case (rem_bytes_q[1:0])
      2'd1:    part_w = {24'b0, s_data[7:0]};
      2'd2:    part_w = {16'b0, s_data[15:0]};
      2'd3:    part_w = {8'b0, s_data[23:0]};
      default: part_w = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arstn) begin
      state_q     <= S_IDLE;
      rem_bytes_q <= '0;
      rem_blank_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_bytes_q <= rem_bytes_d;
      rem_blank_q <= rem_blank_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_bytes_d = rem_bytes_q;
    rem_blank_d = rem_blank_q;
    f_din       = '0;
    f_size      = '0;
    f_valid     = 1'b0;
    s_ready     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          rem_bytes_d = msg_len;
          rem_blank_d = blank_rounds;
          state_d     = (msg_len != '0) ? S_DATA : S_PAD;
        end
      end
      S_DATA: begin
        f_valid = s_valid;
        s_ready = f_ready;
        if (full_w) begin
          f_din  = s_data;
          f_size = 3'b100;
          if (s_valid && f_ready) begin
            rem_bytes_d = rem_bytes_q - LEN_WIDTH'(4);
            if (rem_bytes_q == LEN_WIDTH'(4))
              state_d = S_PAD;
          end
        end else begin
          f_din  = part_w;
          f_size = {1'b0, rem_bytes_q[1:0]};
          if (s_valid && f_ready) begin
            rem_bytes_d = '0;
            state_d = (rem_blank_q != '0) ? S_BLANK : FIN;
          end
        end
      end
      S_PAD: begin
        f_valid = 1'b1;
        if (f_ready)
          state_d = (rem_blank_q != '0) ? S_BLANK : FIN;
      end
      S_BLANK: begin
        f_valid = 1'b1;
        if (f_ready) begin
          rem_blank_d = rem_blank_q - BLANK_WIDTH'(1);
          if (rem_blank_q == BLANK_WIDTH'(1))
            state_d = FIN;
        end
      end
      S_FLUSH: begin
        if (m_din_ready)
          state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
